// File: rtl/led_disp_arbiter.sv
// led_disp_arbiter: round-robin owner of the shared 8-digit seven-segment
// display, with a hold timer per slice and urgent preemption.
// Ports: scan_clk, rst_n (async, active-low); req/urgent/req_digits/req_en
// per requester (req_blink with LED_DISP_BLINK_EN); gnt (one-hot), busy,
// disp_digits/disp_en (registered, one cycle behind gnt) to the scanner.
// Optional blink: define LED_DISP_BLINK_EN.
module led_disp_arbiter #(
  parameter int N_REQ      = 3,
  parameter int HOLD_TICKS = 1024,
  parameter int BLINK_DIV  = 256
) (
  input  logic                 scan_clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     urgent,
  input  logic [32*N_REQ-1:0]  req_digits,
  input  logic [8*N_REQ-1:0]   req_en,
`ifdef LED_DISP_BLINK_EN
  input  logic [N_REQ-1:0]     req_blink,
`endif
  output logic [N_REQ-1:0]     gnt,
  output logic                 busy,
  output logic [31:0]          disp_digits,
  output logic [7:0]           disp_en
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_TICKS - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [31:0]      dig_q, dig_d;
  logic [7:0]       en_q, en_d;

  logic [N_REQ-1:0] cand, urg_cand;
  logic [IW-1:0]    rr_idx, urg_idx, new_idx;
  logic             rr_any, urg_any;
  logic             held, hold_urg, new_gnt;
  int               pos;

`ifdef LED_DISP_BLINK_EN
  localparam int PW = $clog2(BLINK_DIV * 2);
  logic [PW-1:0] ph_q, ph_d;

  assign ph_d = ph_q + PW'(1);

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) ph_q <= '0;
    else        ph_q <= ph_d;
  end
`endif

  assign held     = |(req & gnt_q);
  assign hold_urg = |(req & urgent & gnt_q);
  assign cand     = req & ~gnt_q;
  assign urg_cand = req & urgent & ~gnt_q;
  assign urg_any  = |urg_cand;

  // round-robin: first candidate after the pointer, wrapping
  always_comb begin
    rr_idx = '0;
    rr_any = 1'b0;
    pos    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = (int'(ptr_q) + k) % N_REQ;
      if (!rr_any && cand[IW'(pos)]) begin
        rr_idx = IW'(pos);
        rr_any = 1'b1;
      end
    end
  end

  // lowest-index urgent requester
  always_comb begin
    urg_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (urg_cand[i]) urg_idx = IW'(i);
  end

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      dig_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      dig_q   <= dig_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    new_gnt = 1'b0;
    new_idx = rr_idx;
    unique case (state_q)
      IDLE: new_gnt = rr_any;
      GRANT: begin
        // an urgent holder only yields to urgents once its hold expires
        if (urg_any && (!hold_urg || cnt_q == '0)) begin
          new_gnt = 1'b1;
          new_idx = urg_idx;
        end else if (!held) begin
          if (rr_any) begin
            new_gnt = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rr_any) begin
          new_gnt = 1'b1;
        end else begin
          cnt_d = HOLD_LD;
        end
      end
      default: ;
    endcase
    if (new_gnt) begin
      state_d = GRANT;
      gnt_d   = ONE << new_idx;
      cnt_d   = HOLD_LD;
      ptr_d   = new_idx;
    end
  end

  // display follows the current owner live; blank when idle
  always_comb begin
    dig_d = '0;
    en_d  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        dig_d = req_digits[32*i +: 32];
        en_d  = req_en[8*i +: 8];
      end
    end
`ifdef LED_DISP_BLINK_EN
    if (ph_q[PW-1] && |(req_blink & gnt_q)) en_d = '0;
`endif
  end

  always_comb begin
    gnt         = gnt_q;
    busy        = |gnt_q;
    disp_digits = dig_q;
    disp_en     = en_q;
  end

endmodule
